// File: rtl/seg_pkg.sv
// Shared types and constants for the 4-digit 7-segment scan scheduler:
// FSM state type, hex segment table, idle-level and leading-zero helpers.
package seg_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  // Active-high {g,f,e,d,c,b,a} codes for hex digits 0..F
  localparam logic [6:0] HEX_CODE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] seg_off(input bit act_low);
    return act_low ? 7'h7F : 7'h00;
  endfunction

  function automatic logic [3:0] dig_off(input bit act_low);
    return act_low ? 4'hF : 4'h0;
  endfunction

  // Idle levels for the board's default active-low wiring
  localparam logic [6:0] SEG_OFF = seg_off(1'b1);
  localparam logic [3:0] DIG_OFF = dig_off(1'b1);

  // Digits to suppress as leading zeros; digit 0 is never suppressed
  function automatic logic [3:0] lead_zero_mask(input logic [15:0] v);
    logic [3:0] sup;
    sup[3] = (v[15:12] == 4'h0);
    sup[2] = sup[3] && (v[11:8] == 4'h0);
    sup[1] = sup[2] && (v[7:4] == 4'h0);
    sup[0] = 1'b0;
    return sup;
  endfunction

endpackage

// File: rtl/seg_scan_sched_if.sv
// Display-value update handshake between the datapath (master) and the
// scan scheduler (slave).
interface seg_scan_sched_if;
  logic        upd_valid;
  logic [15:0] upd_data;
  logic [3:0]  upd_mask;
  logic        upd_ready;

  modport master (output upd_valid, upd_data, upd_mask, input upd_ready);
  modport slave  (input upd_valid, upd_data, upd_mask, output upd_ready);
endinterface

// File: rtl/seg_scan_sched_hex2seg.sv
// Combinational hex nibble to 7-segment {g,f,e,d,c,b,a} decoder with
// selectable output polarity.
module hex2seg
  import seg_pkg::*;
#(
  parameter bit ACT_LOW = 1'b1
) (
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb seg = ACT_LOW ? ~HEX_CODE[nib] : HEX_CODE[nib];

endmodule

// File: rtl/seg_scan_sched.sv
// Time-multiplexed 4-digit 7-segment scan scheduler with blanking guard and
// frame-aligned value commit. Optional build macro SEG_LEAD_ZERO_BLANK_EN
// suppresses leading zero digits.
module seg_scan_sched
  import seg_pkg::*;
#(
  parameter int unsigned ON_TICKS    = 4,
  parameter int unsigned BLANK_TICKS = 1,
  parameter bit          SEG_ACT_LOW = 1'b1,
  parameter bit          DIG_ACT_LOW = 1'b1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   tick,
  seg_scan_sched_if.slave        upd,
  output logic [6:0]             ss,
  output logic [3:0]             dig,
  output logic                   frame_done
);

  localparam int unsigned CNT_MAX  = (ON_TICKS > BLANK_TICKS) ?
                                     ((ON_TICKS > 2) ? ON_TICKS : 2) :
                                     ((BLANK_TICKS > 2) ? BLANK_TICKS : 2);
  localparam int unsigned CW       = $clog2(CNT_MAX);
  localparam logic [CW-1:0] ON_LAST    = CW'(ON_TICKS - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_TICKS == 0) ? 0 : BLANK_TICKS - 1);
  localparam logic [6:0] SEG_IDLE = seg_off(SEG_ACT_LOW);
  localparam logic [3:0] DIG_IDLE = dig_off(DIG_ACT_LOW);

  state_t          state, state_nxt;
  logic [1:0]      idx, idx_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            frame_end;

  logic [15:0]     shadow, pend_data;
  logic [3:0]      shadow_mask, pend_mask, show_mask;
  logic            pend_full, accept;

  logic [3:0]      nib;
  logic [6:0]      seg_code, ss_nxt;
  logic [3:0]      dig_nxt;

  // State register; ss/dig are registered copies of the output decode
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= BLANK;
      idx   <= 2'd0;
      cnt   <= '0;
      ss    <= SEG_IDLE;
      dig   <= DIG_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
      ss    <= ss_nxt;
      dig   <= dig_nxt;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through this block leaves a value unassigned (no latches).
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    frame_end = 1'b0;
    unique case (state)
      BLANK: begin
        if (BLANK_TICKS == 0) begin
          // Zero-length guard: a tick seen now already counts toward SHOW
          state_nxt = SHOW;
          cnt_nxt   = (tick && ON_TICKS > 1) ? CW'(1) : '0;
        end else if (tick) begin
          if (cnt == BLANK_LAST) begin
            state_nxt = SHOW;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      SHOW: begin
        if (tick) begin
          if (cnt == ON_LAST) begin
            state_nxt = BLANK;
            idx_nxt   = idx + 2'd1;
            cnt_nxt   = '0;
            frame_end = (idx == 2'd3);
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
    endcase
  end

  assign frame_done    = frame_end;
  assign upd.upd_ready = ~pend_full;
  assign accept        = upd.upd_valid && ~pend_full;

  // Capture needs an empty slot and commit needs a full one, so they never coincide
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pend_full   <= 1'b0;
      pend_data   <= 16'h0000;
      pend_mask   <= 4'h0;
      shadow      <= 16'h0000;
      shadow_mask <= 4'hF;
    end else if (accept) begin
      pend_full <= 1'b1;
      pend_data <= upd.upd_data;
      pend_mask <= upd.upd_mask;
    end else if (frame_end && pend_full) begin
      pend_full   <= 1'b0;
      shadow      <= pend_data;
      shadow_mask <= pend_mask;
    end
  end

`ifdef SEG_LEAD_ZERO_BLANK_EN
  logic [3:0] lz_sup;

  // Suppression is latched with the committed value so it holds for the whole frame
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lz_sup <= 4'h0;
    end else if (!accept && frame_end && pend_full) begin
      lz_sup <= lead_zero_mask(pend_data);
    end
  end

  assign show_mask = shadow_mask & ~lz_sup;
`else
  assign show_mask = shadow_mask;
`endif

  assign nib = shadow[{idx, 2'b00} +: 4];

  hex2seg #(.ACT_LOW(SEG_ACT_LOW)) u_hex2seg (
    .nib (nib),
    .seg (seg_code)
  );

  always_comb begin
    ss_nxt  = SEG_IDLE;
    dig_nxt = DIG_IDLE;
    if (state == SHOW && show_mask[idx]) begin
      ss_nxt  = seg_code;
      dig_nxt = DIG_ACT_LOW ? ~(4'b0001 << idx) : (4'b0001 << idx);
    end
  end

endmodule

// File: tb/tb_seg_scan_sched.sv
// Self-checking bench for seg_scan_sched (ON_TICKS=2, BLANK_TICKS=1, active-low
// segments and digits, tick every clock): frame-by-frame vector table plus a mid-scan reset.
module tb_seg_scan_sched;

  logic       CLK = 1'b0;
  logic       RST;
  logic       tick;
  logic [6:0] ss;
  logic [3:0] dig;
  logic       frame_done;

  seg_scan_sched_if bus();

  seg_scan_sched #(
    .ON_TICKS    (2),
    .BLANK_TICKS (1),
    .SEG_ACT_LOW (1'b1),
    .DIG_ACT_LOW (1'b1)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .tick       (tick),
    .upd        (bus.slave),
    .ss         (ss),
    .dig        (dig),
    .frame_done (frame_done)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;
  int j        = 0;

  // One 12-cycle frame: bus stimulus per step, expected ready per step,
  // and the value on display ({idx3,idx2,idx1,idx0} active-low codes + digit mask)
  typedef struct {
    logic [11:0] vld;
    logic [15:0] d1;
    logic [3:0]  m1;
    logic [15:0] d2;
    logic [3:0]  m2;
    int          sw;
    logic [11:0] rdy;
    logic [27:0] codes;
    logic [3:0]  mask;
  } frame_t;

  frame_t frames [10];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    j++;
    #1;
  endtask

  function automatic logic [3:0] dig_sel(input int idx);
    case (idx)
      0:       return 4'b1110;
      1:       return 4'b1101;
      2:       return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  function automatic frame_t mk(input logic [11:0] vld, input logic [15:0] d1, input logic [3:0] m1,
                                input logic [15:0] d2, input logic [3:0] m2, input int sw,
                                input logic [11:0] rdy, input logic [27:0] codes, input logic [3:0] mask);
    frame_t f;
    f.vld = vld; f.d1 = d1; f.m1 = m1; f.d2 = d2; f.m2 = m2; f.sw = sw;
    f.rdy = rdy; f.codes = codes; f.mask = mask;
    return f;
  endfunction

  // Starts right after a frame boundary edge; slot i shows state i (0,3,6,9 = blank)
  task automatic run_frame(input int fn, input frame_t f);
    int         idx;
    logic [3:0] exp_dig;
    logic [6:0] exp_ss;
    for (int i = 0; i < 12; i++) begin
      bus.upd_valid = f.vld[i];
      bus.upd_data  = (i < f.sw) ? f.d1 : f.d2;
      bus.upd_mask  = (i < f.sw) ? f.m1 : f.m2;
      step();
      idx     = i / 3;
      exp_dig = 4'hF;
      exp_ss  = 7'h7F;
      if ((i % 3) != 0 && f.mask[idx]) begin
        exp_dig = dig_sel(idx);
        exp_ss  = f.codes[idx*7 +: 7];
      end
      check($sformatf("f%0d_s%0d_dig", fn, i), {12'h0, dig}, {12'h0, exp_dig});
      check($sformatf("f%0d_s%0d_ss", fn, i), {9'h0, ss}, {9'h0, exp_ss});
      check($sformatf("f%0d_s%0d_frame_done", fn, i), {15'h0, frame_done}, {15'h0, (i == 10)});
      check($sformatf("f%0d_s%0d_ready", fn, i), {15'h0, bus.upd_ready}, {15'h0, f.rdy[i]});
    end
    bus.upd_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 0000 shown -> push 1234 mid-frame
    frames[0] = mk(12'h008, 16'h1234, 4'hF, 16'h1234, 4'hF, 12, 12'h807,
                   {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF);
    // 1234 shown -> push 5678 with mask 0101
    frames[1] = mk(12'h008, 16'h5678, 4'h5, 16'h5678, 4'h5, 12, 12'h807,
                   {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF);
    // 5678/0101 shown -> ABCD captured, then EEEE held against a full slot
    frames[2] = mk(12'hFFF, 16'hABCD, 4'hF, 16'hEEEE, 4'hF, 1, 12'h800,
                   {7'h7F, 7'h02, 7'h7F, 7'h00}, 4'h5);
    // ABCD shown -> held EEEE captured on the first edge after commit
    frames[3] = mk(12'h001, 16'hEEEE, 4'hF, 16'hEEEE, 4'hF, 12, 12'h800,
                   {7'h08, 7'h03, 7'h46, 7'h21}, 4'hF);
    // EEEE shown -> push 9EF0
    frames[4] = mk(12'h008, 16'h9EF0, 4'hF, 16'h9EF0, 4'hF, 12, 12'h807,
                   {7'h06, 7'h06, 7'h06, 7'h06}, 4'hF);
    // 9EF0 shown -> push 0070
    frames[5] = mk(12'h008, 16'h0070, 4'hF, 16'h0070, 4'hF, 12, 12'h807,
                   {7'h10, 7'h06, 7'h0E, 7'h40}, 4'hF);
`ifdef SEG_LEAD_ZERO_BLANK_EN
    frames[6] = mk(12'h008, 16'h0000, 4'hF, 16'h0000, 4'hF, 12, 12'h807,
                   {7'h40, 7'h40, 7'h78, 7'h40}, 4'h3);
    frames[7] = mk(12'h008, 16'h1234, 4'hF, 16'h1234, 4'hF, 12, 12'h807,
                   {7'h40, 7'h40, 7'h40, 7'h40}, 4'h1);
`else
    frames[6] = mk(12'h008, 16'h0000, 4'hF, 16'h0000, 4'hF, 12, 12'h807,
                   {7'h40, 7'h40, 7'h78, 7'h40}, 4'hF);
    frames[7] = mk(12'h008, 16'h1234, 4'hF, 16'h1234, 4'hF, 12, 12'h807,
                   {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF);
`endif
    // Slot 8 is the hand-written mid-scan reset; slot 9 is the frame after it
    frames[8] = frames[7];
    frames[9] = mk(12'h000, 16'h0000, 4'h0, 16'h0000, 4'h0, 12, 12'hFFF,
                   {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF);

    RST           = 1'b1;
    tick          = 1'b1;
    bus.upd_valid = 1'b0;
    bus.upd_data  = 16'h0000;
    bus.upd_mask  = 4'h0;
    #12;
    check("rst_ss", {9'h0, ss}, 16'h007F);
    check("rst_dig", {12'h0, dig}, 16'h000F);
    check("rst_frame_done", {15'h0, frame_done}, 16'h0000);
    check("rst_ready", {15'h0, bus.upd_ready}, 16'h0001);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    j   = 0;

    for (int f = 0; f < 8; f++) run_frame(f, frames[f]);

    // Run into the second SHOW cycle of idx 2 with 1234 on display
    for (int i = 0; i < 8; i++) step();
    check("pre_rst_dig", {12'h0, dig}, 16'h000B);
    check("pre_rst_ss", {9'h0, ss}, 16'h0024);
    #2;
    RST = 1'b1;
    #1;
    check("async_rst_ss", {9'h0, ss}, 16'h007F);
    check("async_rst_dig", {12'h0, dig}, 16'h000F);
    check("async_rst_frame_done", {15'h0, frame_done}, 16'h0000);
    check("async_rst_ready", {15'h0, bus.upd_ready}, 16'h0001);
    repeat (2) @(posedge CLK);
    #1;
    check("in_rst_dig", {12'h0, dig}, 16'h000F);
    RST = 1'b0;
    j   = 0;
    run_frame(9, frames[9]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
